// File: rtl/vmem_width_conv.sv
// vmem_width_conv: splits one wide vector-memory access into one or two narrow memory beats
// and reassembles the in-order beat responses into a single wide response.
module vmem_width_conv #(
  parameter int VMEM_W = 128,
  parameter int MEM_W  = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                vmem_req_i,
  output logic                vmem_gnt_o,
  input  logic [31:0]         vmem_addr_i,
  input  logic                vmem_we_i,
  input  logic [VMEM_W/8-1:0] vmem_be_i,
  input  logic [VMEM_W-1:0]   vmem_wdata_i,
  output logic                vmem_rvalid_o,
  output logic [VMEM_W-1:0]   vmem_rdata_o,
  output logic                vmem_err_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [31:0]         mem_addr_o,
  output logic                mem_we_o,
  output logic [MEM_W/8-1:0]  mem_be_o,
  output logic [MEM_W-1:0]    mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [MEM_W-1:0]    mem_rdata_i,
  input  logic                mem_err_i
);
  localparam int BW = MEM_W / 8;
  if (VMEM_W != 2 * MEM_W) begin : g_bad_width
    $error("vmem_width_conv: VMEM_W must equal 2*MEM_W");
  end
  typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, WAIT_RSP, RESP} state_t;
  state_t state, state_n;
  logic [27:0]         addr_q;
  logic                we_q, lo_q, hi_q, err_q;
  logic [VMEM_W/8-1:0] be_q;
  logic [VMEM_W-1:0]   wdata_q, rdata_q;
  logic [1:0]          exp_q, rcv_q;
  logic                lo_pl, hi_pl, issue, is_hi, unused_addr;
  // an all-zero write still issues one (empty) lo beat so the upstream gets a response
  assign lo_pl = !vmem_we_i || |vmem_be_i[BW-1:0] || !(|vmem_be_i[2*BW-1:BW]);
  assign hi_pl = !vmem_we_i || |vmem_be_i[2*BW-1:BW];
  assign unused_addr = ^vmem_addr_i[3:0];
  assign vmem_gnt_o = state == IDLE && vmem_req_i;
  assign issue = state == ISSUE_LO || state == ISSUE_HI;
  assign is_hi = state == ISSUE_HI;
  assign mem_req_o = issue;
  assign mem_addr_o = issue ? {addr_q, is_hi, 3'b000} : '0;
  assign mem_we_o = issue && we_q;
  assign mem_be_o = issue ? (is_hi ? be_q[2*BW-1:BW] : be_q[BW-1:0]) : '0;
  assign mem_wdata_o = issue ? (is_hi ? wdata_q[VMEM_W-1:MEM_W] : wdata_q[MEM_W-1:0]) : '0;
  assign vmem_rvalid_o = state == RESP;
  assign vmem_rdata_o = rdata_q;
  assign vmem_err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (vmem_req_i) state_n = lo_pl ? ISSUE_LO : ISSUE_HI;
      ISSUE_LO: if (mem_gnt_i) state_n = hi_q ? ISSUE_HI : WAIT_RSP;
      ISSUE_HI: if (mem_gnt_i) state_n = WAIT_RSP;
      WAIT_RSP: if (rcv_q + 2'(mem_rvalid_i) == exp_q) state_n = RESP;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // responses may arrive while beats are still being issued, so count them in any busy state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lo_q    <= 1'b0;
      hi_q    <= 1'b0;
      err_q   <= 1'b0;
      exp_q   <= '0;
      rcv_q   <= '0;
    end else if (vmem_gnt_o) begin
      addr_q  <= vmem_addr_i[31:4];
      we_q    <= vmem_we_i;
      be_q    <= vmem_be_i;
      wdata_q <= vmem_wdata_i;
      rdata_q <= '0;
      lo_q    <= lo_pl;
      hi_q    <= hi_pl;
      err_q   <= 1'b0;
      exp_q   <= 2'(lo_pl) + 2'(hi_pl);
      rcv_q   <= '0;
    end else if (state != IDLE && mem_rvalid_i) begin
      rcv_q <= rcv_q + 2'd1;
      err_q <= err_q | mem_err_i;
      if (rcv_q == 2'd0 && lo_q) rdata_q[MEM_W-1:0] <= mem_rdata_i;
      else rdata_q[VMEM_W-1:MEM_W] <= mem_rdata_i;
    end
  end
endmodule

// File: doc/vmem_width_conv.md
VMEM_WIDTH_CONV -- requirements
Module: vmem_width_conv

Interface
REQ-001 SHALL have parameter VMEM_W, default 128: upstream vector-memory data width in bits.
REQ-002 SHALL have parameter MEM_W, default 64: downstream memory data width in bits; VMEM_W == 2*MEM_W required, elaboration error otherwise.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 vmem_req_i  in  1  upstream request valid, held until granted.
REQ-006 vmem_gnt_o  out  1  upstream request accepted.
REQ-007 vmem_addr_i  in  32  upstream byte address; bits [3:0] ignored.
REQ-008 vmem_we_i  in  1  1 = write, 0 = read.
REQ-009 vmem_be_i  in  VMEM_W/8  upstream byte enables.
REQ-010 vmem_wdata_i  in  VMEM_W  upstream write data.
REQ-011 vmem_rvalid_o  out  1  upstream response valid, one-cycle pulse.
REQ-012 vmem_rdata_o  out  VMEM_W  assembled read data.
REQ-013 vmem_err_o  out  1  response error, qualified by vmem_rvalid_o.
REQ-014 mem_req_o / mem_gnt_i  out/in  1/1  downstream request/grant.
REQ-015 mem_addr_o  out  32  downstream beat address.
REQ-016 mem_we_o / mem_be_o / mem_wdata_o  out  1 / MEM_W/8 / MEM_W  downstream beat write-enable, byte enables, data.
REQ-017 mem_rvalid_i / mem_rdata_i / mem_err_i  in  1 / MEM_W / 1  downstream in-order beat response.

Function
REQ-018 States: IDLE, ISSUE_LO, ISSUE_HI, WAIT_RSP, RESP.
REQ-019 IDLE: vmem_gnt_o = vmem_req_i (combinational); on grant, register addr, we, be, wdata; compute beat plan.
REQ-020 Beat plan: read -> lo and hi beats. Write -> lo beat iff be[7:0]!=0; hi beat iff be[15:8]!=0; both zero -> lo beat only, be 0.
REQ-021 IDLE transition on grant: to ISSUE_LO if lo beat planned, else ISSUE_HI.
REQ-022 Lo beat: addr {addr[31:4],4'h0}, be/wdata from low halves. Hi beat: addr {addr[31:4],4'h8}, be/wdata from high halves.
REQ-023 mem_req_o asserted only in ISSUE_LO/ISSUE_HI; addr/we/be/wdata held stable until mem_gnt_i.
REQ-024 ISSUE_LO + mem_gnt_i: to ISSUE_HI if hi beat planned, else WAIT_RSP. ISSUE_HI + mem_gnt_i: to WAIT_RSP.
REQ-025 2-bit expected-beat count (1 or 2) and received-beat count; mem_rvalid_i increments received in any non-IDLE state, including ISSUE_HI.
REQ-026 Beat responses return in issue order: first response fills the lower half if lo beat planned, else the upper half; second fills the upper half.
REQ-027 Unplanned halves of vmem_rdata_o read 0; rdata register cleared on IDLE grant.
REQ-028 vmem_err_o = OR of mem_err_i over all beats of the transaction.
REQ-029 WAIT_RSP: when received == expected (counting a same-cycle mem_rvalid_i), go to RESP.
REQ-030 RESP: vmem_rvalid_o = 1 for exactly one cycle with registered rdata/err; next state IDLE.
REQ-031 One upstream transaction outstanding; vmem_gnt_o = 0 in every state except IDLE.
REQ-032 Minimum latency, zero-wait downstream: grant cycle T; lo beat T+1; hi beat T+2; responses same cycle as grant at earliest; vmem_rvalid_o at T+4.
REQ-033 mem_rvalid_i in IDLE (stale after reset) is ignored; no state change.

Reset
REQ-034 Reset forces IDLE and clears all registers; vmem_gnt_o follows vmem_req_i, all other outputs 0.
REQ-035 Reset mid-transaction abandons it; no upstream response is ever produced for it.

Verification
REQ-036 Read addr 0x1000_0010, zero-wait memory returning 0xAAAA.. then 0xBBBB.. -> beats at 0x1000_0010 and 0x1000_0018; vmem_rdata_o = {0xBBBB..,0xAAAA..}, rvalid at T+4, err 0.
REQ-037 Write be=0xFF00, wdata high half 0x1234.. -> single beat addr +8, mem_be_o 0xFF, mem_wdata_o 0x1234..; one rvalid, rdata 0.
REQ-038 Write be=0x0000 -> one lo beat with mem_be_o 0; one upstream rvalid.
REQ-039 Read with mem_gnt_i low 3 cycles on the lo beat and err on the hi response -> mem_req_o/addr stable while stalled; vmem_err_o = 1 with rvalid.
REQ-040 Lo response arriving in the same cycle as the hi-beat grant -> count correct, exactly one rvalid; vmem_gnt_o low until the cycle after RESP.
REQ-041 rst_ni low during WAIT_RSP, then late mem_rvalid_i -> no vmem_rvalid_o; next request serviced normally.
